// File: rtl/traffic_light_ctrl.sv
// Traffic light sequencer: IDLE -> GREEN -> YELLOW -> RED -> GREEN, paced by Tick and gated by Run.
// Optional build macro FLASH_YELLOW_EN makes Yellow blink on Tick while IDLE.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_T  = 30,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned RED_T    = 30
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Tick,
    input  logic       Run,
    output logic       Red,
    output logic       Yellow,
    output logic       Green,
    output logic [6:0] Count,
    output logic       Cycle_done,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_RED    = 2'd3
    } state_t;

    localparam logic [6:0] GREEN_LEN  = 7'(GREEN_T);
    localparam logic [6:0] YELLOW_LEN = 7'(YELLOW_T);
    localparam logic [6:0] RED_LEN    = 7'(RED_T);

    state_t     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic       cycle_q, cycle_d;
    logic [2:0] lamps_q, lamps_d;  // {red, yellow, green}
`ifdef FLASH_YELLOW_EN
    logic       flash_q, flash_d;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            count_q <= 7'd0;
            cycle_q <= 1'b0;
            lamps_q <= 3'b000;
`ifdef FLASH_YELLOW_EN
            flash_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cycle_q <= cycle_d;
            lamps_q <= lamps_d;
`ifdef FLASH_YELLOW_EN
            flash_q <= flash_d;
`endif
        end
    end

    // Run=0 wins over everything; Tick on the IDLE->GREEN edge is ignored.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cycle_d = 1'b0;
        if (!Run) begin
            state_d = S_IDLE;
            count_d = 7'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_GREEN;
                    count_d = GREEN_LEN;
                end
                S_GREEN: begin
                    if (Tick) begin
                        if (count_q > 7'd1) begin
                            count_d = count_q - 7'd1;
                        end else begin
                            state_d = S_YELLOW;
                            count_d = YELLOW_LEN;
                        end
                    end
                end
                S_YELLOW: begin
                    if (Tick) begin
                        if (count_q > 7'd1) begin
                            count_d = count_q - 7'd1;
                        end else begin
                            state_d = S_RED;
                            count_d = RED_LEN;
                        end
                    end
                end
                S_RED: begin
                    if (Tick) begin
                        if (count_q > 7'd1) begin
                            count_d = count_q - 7'd1;
                        end else begin
                            state_d = S_GREEN;
                            count_d = GREEN_LEN;
                            cycle_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = 7'd0;
                end
            endcase
        end
    end

    // Lamps are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        lamps_d = 3'b000;
`ifdef FLASH_YELLOW_EN
        flash_d = 1'b0;
        if (state_d == S_IDLE) begin
            // Entering IDLE restarts the blink dark; only Ticks spent in IDLE toggle it.
            if (state_q == S_IDLE && Tick) begin
                flash_d = ~flash_q;
            end else if (state_q == S_IDLE) begin
                flash_d = flash_q;
            end
        end
`endif
        case (state_d)
            S_GREEN:  lamps_d = 3'b001;
            S_YELLOW: lamps_d = 3'b010;
            S_RED:    lamps_d = 3'b100;
`ifdef FLASH_YELLOW_EN
            default:  lamps_d = {1'b0, flash_d, 1'b0};
`else
            default:  lamps_d = 3'b000;
`endif
        endcase
    end

    assign Red        = lamps_q[2];
    assign Yellow     = lamps_q[1];
    assign Green      = lamps_q[0];
    assign Count      = count_q;
    assign Cycle_done = cycle_q;
    assign State      = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed phase walks plus random Run/Tick
// traffic compared against a phase-table reference model.
module tb_traffic_light_ctrl;

    localparam int G_T = 5;
    localparam int Y_T = 2;
    localparam int R_T = 4;

    logic       CLK;
    logic       RST_n;
    logic       Tick;
    logic       Run;
    logic       Red, Yellow, Green;
    logic [6:0] Count;
    logic       Cycle_done;
    logic [1:0] State;

    int total = 0;
    int bad   = 0;

    traffic_light_ctrl #(
        .GREEN_T (G_T),
        .YELLOW_T(Y_T),
        .RED_T   (R_T)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Tick      (Tick),
        .Run       (Run),
        .Red       (Red),
        .Yellow    (Yellow),
        .Green     (Green),
        .Count     (Count),
        .Cycle_done(Cycle_done),
        .State     (State)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // reference model: phase index into a table of lengths, and ticks elapsed in that phase
    int phase_len[3] = '{G_T, Y_T, R_T};
    bit m_active;
    int m_phase;
    int m_elapsed;
    bit m_cd;
    bit m_flash;

    task automatic model_reset();
        m_active  = 0;
        m_phase   = 0;
        m_elapsed = 0;
        m_cd      = 0;
        m_flash   = 0;
    endtask

    task automatic model_edge(input bit run, input bit tick);
        m_cd = 0;
        if (!run) begin
            if (m_active) m_flash = 0;
            else if (tick) m_flash = !m_flash;
            m_active = 0;
        end else if (!m_active) begin
            m_active  = 1;
            m_phase   = 0;
            m_elapsed = 0;
            m_flash   = 0;
        end else if (tick) begin
            m_elapsed++;
            if (m_elapsed == phase_len[m_phase]) begin
                if (m_phase == 2) m_cd = 1;
                m_phase   = (m_phase + 1) % 3;
                m_elapsed = 0;
            end
        end
    endtask

    function automatic int exp_count();
        return m_active ? phase_len[m_phase] - m_elapsed : 0;
    endfunction

    function automatic logic [2:0] exp_lamps();
        if (!m_active) begin
`ifdef FLASH_YELLOW_EN
            return {1'b0, m_flash, 1'b0};
`else
            return 3'b000;
`endif
        end
        case (m_phase)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // scoreboard check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("lamps", {29'd0, Red, Yellow, Green}, {29'd0, exp_lamps()});
        chk("count", {25'd0, Count}, exp_count());
        chk("cycle_done", {31'd0, Cycle_done}, {31'd0, m_cd});
        chk("red_green_excl", {31'd0, Red & Green}, 32'd0);
    endtask

    // driver: inputs applied at negedge, model stepped at posedge, outputs checked at next negedge
    task automatic step(input bit run, input bit tick);
        Run  = run;
        Tick = tick;
        @(posedge CLK);
        model_edge(run, tick);
        @(negedge CLK);
        check_all();
    endtask

    // tick 1-in-10 until the model reaches the given phase/remaining count
    task automatic run_until(input int phase, input int remaining, input string tag);
        int c = 0;
        while (!(m_active && m_phase == phase && exp_count() == remaining)) begin
            if (c >= 500) begin
                chk({tag, "_timeout"}, 32'd1, 32'd0);
                return;
            end
            step(1, (c % 10) == 9);
            c++;
        end
    endtask

    initial begin
        int pulses;
        model_reset();
        RST_n = 1'b0;
        Run   = 1'b1;
        Tick  = 1'b0;
        #12;
        // reset state
        chk("rst_lamps", {29'd0, Red, Yellow, Green}, 32'd0);
        chk("rst_count", {25'd0, Count}, 32'd0);
        chk("rst_cd", {31'd0, Cycle_done}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        // Run held through reset: GREEN with full count at the first edge
        step(1, 0);
        chk("first_green", {29'd0, Red, Yellow, Green}, 32'd1);
        chk("first_count", {25'd0, Count}, G_T);

        // asynchronous reset in RED with Count=3
        run_until(2, 3, "to_red3");
        chk("red3_lamp", {31'd0, Red}, 32'd1);
        #2 RST_n = 1'b0;
        #1;
        model_reset();
        chk("async_lamps", {29'd0, Red, Yellow, Green}, 32'd0);
        chk("async_count", {25'd0, Count}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        step(0, 0);
        chk("idle_after_rst", {25'd0, Count}, 32'd0);

        // full sequence with Tick every 10 clocks: exactly one Cycle_done pulse
        step(1, 0);
        pulses = 0;
        for (int c = 0; c < 150; c++) begin
            step(1, (c % 10) == 9);
            if (Cycle_done) pulses++;
        end
        chk("cd_pulses", pulses, 32'd1);

        // Run falls with the Tick that ends YELLOW: straight to IDLE, no Red
        run_until(1, 1, "to_yel1");
        step(0, 1);
        chk("yel_abort_red", {31'd0, Red}, 32'd0);
        chk("yel_abort_cnt", {25'd0, Count}, 32'd0);

        // Run rises with a Tick: GREEN with full count, Tick ignored
        step(0, 0);
        step(1, 1);
        chk("rise_tick_cnt", {25'd0, Count}, G_T);

        // hold in YELLOW with Count=2 and no Tick for 1000 cycles
        run_until(1, 2, "to_yel2");
        for (int c = 0; c < 1000; c++) step(1, 0);
        chk("hold_yel", {31'd0, Yellow}, 32'd1);
        chk("hold_cnt", {25'd0, Count}, 32'd2);

        // idle lamps with ticks while Run=0
        step(0, 0);
        for (int c = 0; c < 4; c++) step(0, 1);

        // random Run/Tick traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
